// File: rtl/add_display_ctrl.sv
// Add-and-display controller: handshake-loaded 4-bit operands, 5-bit sum, 4-digit scan.
// Optional overflow blink of the whole display: define ADD_DISPLAY_OVF_BLINK_EN.
module add_display_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       done,
  output logic       OVERFLOW,
  output logic [3:0] AN,
  output logic [6:0] DISPLAY
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SUM} state_e;

  state_e     state_q, state_d;
  logic       load_ready_q, load_ready_d;
  logic       done_q, done_d;
  logic       capture_c, sum_en_c;
  logic [3:0] a_q, b_q, sum_q;
  logic       ovf_q;
  logic [DIV_W-1:0] tick_q;
  logic [1:0] idx_q;
  logic       wrap_c;
  logic       blank_c;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_ready_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= load_ready_d;
      done_q       <= done_d;
    end
  end

  // Next state: IDLE accepts a pair, SUM spends exactly one cycle adding
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    capture_c = 1'b0;
    sum_en_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          capture_c = 1'b1;
          state_d   = SUM;
        end
      end
      SUM: begin
        sum_en_c = 1'b1;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == IDLE);
  end

  // Operand and sum registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      sum_q <= 4'd0;
      ovf_q <= 1'b0;
    end else begin
      if (capture_c) begin
        a_q <= a;
        b_q <= b;
      end
      if (sum_en_c) {ovf_q, sum_q} <= {1'b0, a_q} + {1'b0, b_q};
    end
  end

  assign wrap_c = (tick_q == TICK_LAST);

  // Free-running refresh tick and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
    end else if (wrap_c) begin
      tick_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      tick_q <= tick_q + DIV_W'(1);
    end
  end

`ifdef ADD_DISPLAY_OVF_BLINK_EN
  logic [5:0] frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          frame_q <= 6'd0;
    else if (wrap_c && idx_q == 2'd3) frame_q <= frame_q + 6'd1;
  end

  assign blank_c = ovf_q & frame_q[5];
`else
  assign blank_c = 1'b0;
`endif

  // Digit select and segment content
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    case (idx_q)
      2'd0: begin an_d = 4'b1110; seg_d = ovf_q ? 7'b1111001 : 7'b1111111; end
      2'd1: begin an_d = 4'b1101; seg_d = hex7(sum_q); end
      2'd2: begin an_d = 4'b1011; seg_d = hex7(b_q); end
      default: begin an_d = 4'b0111; seg_d = hex7(a_q); end
    endcase
    if (blank_c) an_d = 4'b1111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign load_ready = load_ready_q;
  assign done       = done_q;
  assign OVERFLOW   = ovf_q;
  assign AN         = an_q;
  assign DISPLAY    = seg_q;

endmodule
